free_list_nport: RTL and testbench
==================================

Name: free_list_nport

Overview:
- Parametrised N-port free list of physical register tags for the superscalar rename stage; successor to the fixed 3-port index-valued buffer.
- Stores real tag values, so freed tags are written back and reused in any order.
- Supports NUM_ALLOC allocate ports and NUM_FREE free ports per cycle, with all-or-nothing allocation.
- Supports NUM_CKPT head-pointer checkpoints for branch misprediction recovery.

Parameters:
- DEPTH, 32: number of entries; power of 2.
- TAG_W, 6: width of a stored tag.
- TAG_OFFSET, 32: entry i resets to tag i+TAG_OFFSET. TAG_OFFSET+DEPTH-1 must fit in TAG_W.
- NUM_ALLOC, 3: allocate ports, 1..4.
- NUM_FREE, 3: free ports, 1..4.
- NUM_CKPT, 4: checkpoint slots, power of 2.
- AW, $clog2(DEPTH): index width; pointers are AW+1 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  NUM_ALLOC  per-port allocate request.
- alloc_ready  out  1  high when the current request set can be granted in full.
- alloc_valid  out  NUM_ALLOC  per-port grant.
- alloc_tag  out  NUM_ALLOC x TAG_W  granted tag; 0 when not granted.
- free_en  in  NUM_FREE  per-port return of a tag.
- free_tag  in  NUM_FREE x TAG_W  tag being returned.
- ckpt_save  in  1  snapshot the head pointer.
- ckpt_save_id  in  $clog2(NUM_CKPT)  slot to write.
- ckpt_restore  in  1  restore the head pointer from a slot.
- ckpt_restore_id  in  $clog2(NUM_CKPT)  slot to read.
- count  out  AW+1  number of free entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow_err  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, rst high at the edge):
  - mem[i] = i+TAG_OFFSET; head = 0; tail = DEPTH (MSB set, low bits 0).
  - All checkpoint slots = 0; overflow_err = 0.
  - Resulting outputs: count = DEPTH, full = 1, empty = 0, alloc_ready = 1.
  - rst overrides every other input in the same cycle.
- count = tail - head, modulo 2^(AW+1).
- Allocation (combinational from registered state, zero latency):
  - n_req = popcount(alloc_req).
  - alloc_ready = (count >= n_req) && !ckpt_restore.
  - If alloc_ready: the k-th requesting port, in ascending index order, gets alloc_valid=1 and alloc_tag = mem[(head+k) mod DEPTH].
  - Else: no grants and head is unchanged.
  - No partial grants. n_req=0 is always ready.
- Head update: head_next = head + n_req when granted.
- Free:
  - n_free = popcount(free_en).
  - The k-th enabled port writes mem[(tail+k) mod DEPTH] = free_tag; tail_next = tail + n_free.
  - If count - granted + n_free > DEPTH: all frees in that cycle are dropped and overflow_err is set (cleared only by rst).
- Same-cycle alloc and free:
  - Allocation sees only the pre-edge count and pre-edge mem; a freed tag is never bypassed to an allocate port in the same cycle.
  - Both pointers update at the same edge.
- Checkpoint save: slot[ckpt_save_id] <= head_next, i.e. the head after this cycle's grants.
- Checkpoint restore:
  - head <= slot[ckpt_restore_id]; grants are suppressed that cycle.
  - Frees in the same cycle are still processed; tail is unaffected.
- Restore and save in the same cycle: restore wins and the save is ignored, whether or not the slot IDs match.
- Wrap-around: pointers wrap modulo 2^(AW+1); the index is ptr[AW-1:0]; the MSB distinguishes full from empty.
- Timing: no combinational path from free_* to alloc_*.

Optional Feature:
- Macro: FREE_LIST_STATS_EN.
- Defined:
  - Adds output ports stat_allocs, stat_frees and stat_stalls, each 32 bits.
  - stat_allocs counts granted tags; stat_frees counts accepted frees; stat_stalls counts cycles with n_req>0 && !alloc_ready.
  - Counters saturate at all-ones and clear on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package free_list_pkg:
  - Default parameter constants.
  - A function ptr_count(tail, head, AW) returning the modular distance.
  - A function popcount4 for request/enable vectors of 4 bits or fewer.
- Sub-module port_compactor (parametrised width):
  - Input: an enable vector.
  - Outputs: per-port prefix offset k and the total popcount.
  - Instantiated once for allocation and once for free.

Test Plan:
- Reset, then alloc_req=3'b111 for one cycle: tags 32, 33, 34 granted on ports 0-2; next cycle count=29.
- Reset, alloc_req=3'b101: ports 0 and 2 get 32 and 33; port 1 gets no grant and alloc_tag=0.
- Drain to count=2, then alloc_req=3'b111: alloc_ready=0, no grants, count stays 2. With alloc_req=3'b011: tags granted, count becomes 0, empty=1.
- Free tags 50, 40, 45 in one cycle at tail index 0, then allocate through the wrap: tags returned in order 50, 40, 45; pointer MSB toggles.
- Sequence:
  - Cycle 1: save slot 1 at head=3.
  - Cycle 2: allocate 3 (head=6).
  - Cycle 3: restore slot 1 together with alloc_req=3'b001 and a save to slot 1.
  - Expected: no grant; head=3; slot 1 keeps the value 3.
- At full, free_en=3'b001: overflow_err=1, tail unchanged; overflow_err stays 1 until rst. Repeat with FREE_LIST_STATS_EN defined to check the counters.

Source files
------------

// File: rtl/free_list_nport_pkg.sv
// Shared constants and helpers for the N-port physical tag free list.
// Imported by the interface, the port compactor and the top.
package free_list_pkg;

    localparam int DEF_DEPTH      = 32;
    localparam int DEF_TAG_W      = 6;
    localparam int DEF_TAG_OFFSET = 32;
    localparam int DEF_NUM_ALLOC  = 3;
    localparam int DEF_NUM_FREE   = 3;
    localparam int DEF_NUM_CKPT   = 4;

    // Modular distance tail-head on (aw+1)-bit pointers.
    function automatic logic [31:0] ptr_count(
        input logic [31:0] tail,
        input logic [31:0] head,
        input int          aw
    );
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (tail - head) & mask;
    endfunction

    // Population count of a request/enable vector of up to 4 bits.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]}
             + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction

endpackage

// File: rtl/free_list_nport_if.sv
// Allocate/free bundle between the rename stage and the free list.
// master = rename stage, slave = free list.
interface free_list_nport_if
    import free_list_pkg::*;
#(
    parameter int NUM_ALLOC = DEF_NUM_ALLOC,
    parameter int NUM_FREE  = DEF_NUM_FREE,
    parameter int TAG_W     = DEF_TAG_W
);
    logic [NUM_ALLOC-1:0]            alloc_req;
    logic                            alloc_ready;
    logic [NUM_ALLOC-1:0]            alloc_valid;
    logic [NUM_ALLOC-1:0][TAG_W-1:0] alloc_tag;
    logic [NUM_FREE-1:0]             free_en;
    logic [NUM_FREE-1:0][TAG_W-1:0]  free_tag;

    modport master (
        output alloc_req, free_en, free_tag,
        input  alloc_ready, alloc_valid, alloc_tag
    );

    modport slave (
        input  alloc_req, free_en, free_tag,
        output alloc_ready, alloc_valid, alloc_tag
    );
endinterface

// File: rtl/free_list_nport_port_compactor.sv
// Maps a sparse enable vector onto consecutive slots: each port gets
// the number of enabled ports below it, plus the total count.
module port_compactor
    import free_list_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0]      en_i,
    output logic [W-1:0][2:0] off_o,
    output logic [2:0]        total_o
);
    logic [2:0] acc;
    logic [3:0] en4;

    // Running prefix sum gives each enabled port its slot offset.
    always_comb begin
        en4        = '0;
        en4[W-1:0] = en_i;
        acc        = '0;
        for (int i = 0; i < W; i++) begin
            off_o[i] = acc;
            acc      = acc + {2'b0, en_i[i]};
        end
        total_o = popcount4(en4);
    end
endmodule

// File: rtl/free_list_nport.sv
// N-port free list of physical tags with head checkpoints.
// Optional FREE_LIST_STATS_EN adds saturating usage counters.
module free_list_nport
    import free_list_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int TAG_OFFSET = DEF_TAG_OFFSET,
    parameter int NUM_ALLOC  = DEF_NUM_ALLOC,
    parameter int NUM_FREE   = DEF_NUM_FREE,
    parameter int NUM_CKPT   = DEF_NUM_CKPT,
    parameter int AW         = $clog2(DEPTH),
    parameter int CW         = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    free_list_nport_if.slave    fl,
    input  logic                ckpt_save,
    input  logic [CW-1:0]       ckpt_save_id,
    input  logic                ckpt_restore,
    input  logic [CW-1:0]       ckpt_restore_id,
    output logic [AW:0]         count,
    output logic                empty,
    output logic                full,
    output logic                overflow_err
`ifdef FREE_LIST_STATS_EN
    ,
    output logic [31:0]         stat_allocs,
    output logic [31:0]         stat_frees,
    output logic [31:0]         stat_stalls
`endif
);
    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [AW:0]      head_q, head_d;
    logic [AW:0]      tail_q, tail_d;
    logic [AW:0]      slot_q [NUM_CKPT];
    logic             ovf_q;

    logic [NUM_ALLOC-1:0][2:0] a_off;
    logic [NUM_FREE-1:0][2:0]  f_off;
    logic [2:0]  n_req, n_free, n_grant, n_acc;
    logic        ready, free_ok;
    logic [AW+1:0] occ;

    port_compactor #(.W(NUM_ALLOC)) u_alloc_cmp (
        .en_i    (fl.alloc_req),
        .off_o   (a_off),
        .total_o (n_req)
    );

    port_compactor #(.W(NUM_FREE)) u_free_cmp (
        .en_i    (fl.free_en),
        .off_o   (f_off),
        .total_o (n_free)
    );

    assign count = (AW+1)'(ptr_count(32'(tail_q), 32'(head_q), AW));
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign overflow_err = ovf_q;

    // All-or-nothing grants from registered state; frees never bypass.
    always_comb begin
        ready   = (count >= (AW+1)'(n_req)) && !ckpt_restore;
        n_grant = ready ? n_req : 3'd0;
        for (int p = 0; p < NUM_ALLOC; p++) begin
            fl.alloc_valid[p] = ready && fl.alloc_req[p];
            fl.alloc_tag[p]   = '0;
            if (fl.alloc_valid[p])
                fl.alloc_tag[p] =
                    mem_q[head_q[AW-1:0] + AW'(a_off[p])];
        end
        fl.alloc_ready = ready;
        occ = {1'b0, count} - (AW+2)'(n_grant)
            + (AW+2)'(n_free);
        free_ok = (occ <= (AW+2)'(DEPTH));
        n_acc   = free_ok ? n_free : 3'd0;
        head_d  = ckpt_restore ? slot_q[ckpt_restore_id]
                               : head_q + (AW+1)'(n_grant);
        tail_d  = tail_q + (AW+1)'(n_acc);
    end

    // Pointer and sticky overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= (AW+1)'(DEPTH);
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_q | !free_ok;
        end
    end

    // Tag storage: reset to the identity map, frees packed at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= TAG_W'(i + TAG_OFFSET);
        end else if (free_ok) begin
            for (int p = 0; p < NUM_FREE; p++)
                if (fl.free_en[p])
                    mem_q[tail_q[AW-1:0] + AW'(f_off[p])]
                        <= fl.free_tag[p];
        end
    end

    // Checkpoint slots hold post-grant head; a restore blocks saving.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CKPT; i++)
                slot_q[i] <= '0;
        end else if (ckpt_save && !ckpt_restore) begin
            slot_q[ckpt_save_id] <= head_d;
        end
    end

`ifdef FREE_LIST_STATS_EN
    logic [31:0] sa_q, sa_d, sf_q, sf_d, ss_q, ss_d;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [2:0]  b
    );
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? '1 : s[31:0];
    endfunction

    // Saturating next values for the usage counters.
    always_comb begin
        sa_d = sat_add(sa_q, n_grant);
        sf_d = sat_add(sf_q, n_acc);
        ss_d = sat_add(ss_q,
                       {2'b0, (n_req != 3'd0) && !ready});
    end

    // Usage counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q <= '0;
            sf_q <= '0;
            ss_q <= '0;
        end else begin
            sa_q <= sa_d;
            sf_q <= sf_d;
            ss_q <= ss_d;
        end
    end

    assign stat_allocs = sa_q;
    assign stat_frees  = sf_q;
    assign stat_stalls = ss_q;
`endif

endmodule

// File: tb/tb_free_list_nport.sv
// Bench for free_list_nport: vector table, then hand sequences for
// overflow, drain/wrap and (with FREE_LIST_STATS_EN) the counters.
module tb_free_list_nport;

    logic       clk;
    logic       rst;
    logic       ckpt_save;
    logic [1:0] ckpt_save_id;
    logic       ckpt_restore;
    logic [1:0] ckpt_restore_id;
    logic [5:0] count;
    logic       empty, full, overflow_err;
`ifdef FREE_LIST_STATS_EN
    logic [31:0] stat_allocs, stat_frees, stat_stalls;
`endif

    int nchecks = 0;
    int nerr    = 0;

    free_list_nport_if #(
        .NUM_ALLOC(3), .NUM_FREE(3), .TAG_W(6)
    ) fif ();

    free_list_nport dut (
        .clk             (clk),
        .rst             (rst),
        .fl              (fif.slave),
        .ckpt_save       (ckpt_save),
        .ckpt_save_id    (ckpt_save_id),
        .ckpt_restore    (ckpt_restore),
        .ckpt_restore_id (ckpt_restore_id),
        .count           (count),
        .empty           (empty),
        .full            (full),
        .overflow_err    (overflow_err)
`ifdef FREE_LIST_STATS_EN
        ,
        .stat_allocs     (stat_allocs),
        .stat_frees      (stat_frees),
        .stat_stalls     (stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      req;
        logic [2:0]      fen;
        logic [2:0][5:0] ftag;
        logic            sv;
        logic [1:0]      svid;
        logic            rs;
        logic [1:0]      rsid;
        logic            rdy;
        logic [2:0]      vld;
        logic [2:0][5:0] tag;
        logic [5:0]      cnt;
    } vec_t;

    vec_t tv[$];
    vec_t exp_q[$];
    int unsigned tq[$];

    function automatic vec_t mk(
        input logic [2:0] req, input logic [2:0] fen,
        input logic [5:0] f0, input logic sv,
        input logic [1:0] svid, input logic rs,
        input logic [1:0] rsid, input logic rdy,
        input logic [2:0] vld, input logic [5:0] t0,
        input logic [5:0] t1, input logic [5:0] t2,
        input logic [5:0] cnt
    );
        vec_t v;
        v.req  = req;
        v.fen  = fen;
        v.ftag = {6'd0, 6'd0, f0};
        v.sv   = sv;
        v.svid = svid;
        v.rs   = rs;
        v.rsid = rsid;
        v.rdy  = rdy;
        v.vld  = vld;
        v.tag  = {t2, t1, t0};
        v.cnt  = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        nchecks++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s got %0d want %0d", nm, a, e);
        end
    endtask

    task automatic idle();
        fif.alloc_req   = '0;
        fif.free_en     = '0;
        fif.free_tag    = '0;
        ckpt_save       = 1'b0;
        ckpt_save_id    = '0;
        ckpt_restore    = 1'b0;
        ckpt_restore_id = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Checks grants on all ports against the in-order tag scoreboard.
    task automatic chk_grants(input string nm, input logic [2:0] req);
        int unsigned e;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("%s_v%0d", nm, p),
                32'(fif.alloc_valid[p]), 32'(req[p]));
            if (req[p]) begin
                if (tq.size() == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL %s_sb empty scoreboard", nm);
                end else begin
                    e = tq.pop_front();
                    chk($sformatf("%s_t%0d", nm, p),
                        32'(fif.alloc_tag[p]), e);
                end
            end else begin
                chk($sformatf("%s_t%0d", nm, p),
                    32'(fif.alloc_tag[p]), 0);
            end
        end
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        idle();

        //        req   fen   ft  sv svid rs rsid rdy vld t0 t1 t2 cnt
        tv.push_back(mk(3'd7, 3'd0, 0, 0, 0, 0, 0, 1, 3'd7, 32, 33, 34, 32));
        tv.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 29));
        tv.push_back(mk(3'd5, 3'd0, 0, 0, 0, 0, 0, 1, 3'd5, 35, 0, 36, 29));
        tv.push_back(mk(3'd0, 3'd0, 0, 1, 1, 0, 0, 1, 3'd0, 0, 0, 0, 27));
        tv.push_back(mk(3'd7, 3'd0, 0, 0, 0, 0, 0, 1, 3'd7, 37, 38, 39, 27));
        tv.push_back(mk(3'd1, 3'd0, 0, 1, 1, 1, 1, 0, 3'd0, 0, 0, 0, 24));
        tv.push_back(mk(3'd1, 3'd0, 0, 0, 0, 0, 0, 1, 3'd1, 37, 0, 0, 27));
        tv.push_back(mk(3'd0, 3'd0, 0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 0, 26));
        tv.push_back(mk(3'd1, 3'd0, 0, 0, 0, 0, 0, 1, 3'd1, 37, 0, 0, 27));
        tv.push_back(mk(3'd0, 3'd1, 50, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 26));
        tv.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 27));
        tv.push_back(mk(3'd2, 3'd0, 0, 0, 0, 0, 0, 1, 3'd2, 0, 38, 0, 27));
        tv.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 26));

        do_reset();
        foreach (tv[i]) begin
            fif.alloc_req   = tv[i].req;
            fif.free_en     = tv[i].fen;
            fif.free_tag    = tv[i].ftag;
            ckpt_save       = tv[i].sv;
            ckpt_save_id    = tv[i].svid;
            ckpt_restore    = tv[i].rs;
            ckpt_restore_id = tv[i].rsid;
            exp_q.push_back(tv[i]);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d_rdy", i),
                32'(fif.alloc_ready), 32'(e.rdy));
            chk($sformatf("v%0d_vld", i),
                32'(fif.alloc_valid), 32'(e.vld));
            for (int p = 0; p < 3; p++)
                chk($sformatf("v%0d_tag%0d", i, p),
                    32'(fif.alloc_tag[p]), 32'(e.tag[p]));
            chk($sformatf("v%0d_cnt", i), 32'(count), 32'(e.cnt));
            chk($sformatf("v%0d_full", i),
                32'(full), 32'(e.cnt == 6'd32));
            chk($sformatf("v%0d_empty", i),
                32'(empty), 32'(e.cnt == 6'd0));
            @(negedge clk);
        end

        // Overflow at full, stickiness, dropped free, reset clear.
        do_reset();
        idle();
        #1;
        chk("a_cnt0", 32'(count), 32);
        chk("a_full0", 32'(full), 1);
        chk("a_empty0", 32'(empty), 0);
        chk("a_rdy0", 32'(fif.alloc_ready), 1);
        chk("a_ovf0", 32'(overflow_err), 0);
        @(negedge clk);
        fif.alloc_req   = 3'b001;
        fif.free_en     = 3'b001;
        fif.free_tag[0] = 6'd7;
        #1;
        chk("a_swap_v", 32'(fif.alloc_valid), 1);
        chk("a_swap_t", 32'(fif.alloc_tag[0]), 32);
        @(negedge clk);
        idle();
        #1;
        chk("a_swap_cnt", 32'(count), 32);
        chk("a_swap_ovf", 32'(overflow_err), 0);
        @(negedge clk);
        fif.free_en     = 3'b001;
        fif.free_tag[0] = 6'd9;
        @(negedge clk);
        idle();
        #1;
        chk("a_ovf1", 32'(overflow_err), 1);
        chk("a_ovf_cnt", 32'(count), 32);
        repeat (3) @(negedge clk);
        #1;
        chk("a_ovf_hold", 32'(overflow_err), 1);
        @(negedge clk);
        fif.alloc_req = 3'b001;
        #1;
        chk("a_after_t", 32'(fif.alloc_tag[0]), 33);
        @(negedge clk);
        idle();
        #1;
        chk("a_after_cnt", 32'(count), 31);
        chk("a_after_ovf", 32'(overflow_err), 1);
        do_reset();
        #1;
        chk("a_rst_ovf", 32'(overflow_err), 0);
        chk("a_rst_cnt", 32'(count), 32);

        // Drain to 2, stall, drain to empty, free three and wrap.
        do_reset();
        tq.delete();
        for (int t = 32; t < 64; t++) tq.push_back(t);
        for (int c = 0; c < 10; c++) begin
            fif.alloc_req = 3'b111;
            #1;
            chk($sformatf("b_cnt%0d", c), 32'(count), 32 - 3 * c);
            chk($sformatf("b_rdy%0d", c), 32'(fif.alloc_ready), 1);
            chk_grants($sformatf("b_g%0d", c), 3'b111);
            @(negedge clk);
        end
        idle();
        fif.alloc_req = 3'b111;
        #1;
        chk("b_stall_cnt", 32'(count), 2);
        chk("b_stall_rdy", 32'(fif.alloc_ready), 0);
        chk_grants("b_stall", 3'b000);
        @(negedge clk);
        idle();
        #1;
        chk("b_hold_cnt", 32'(count), 2);
        @(negedge clk);
        fif.alloc_req = 3'b011;
        #1;
        chk("b_last_rdy", 32'(fif.alloc_ready), 1);
        chk_grants("b_last", 3'b011);
        @(negedge clk);
        idle();
        #1;
        chk("b_empty_cnt", 32'(count), 0);
        chk("b_empty", 32'(empty), 1);
        chk("b_empty_full", 32'(full), 0);
        chk("b_empty_rdy0", 32'(fif.alloc_ready), 1);
        @(negedge clk);
        fif.alloc_req = 3'b001;
        fif.free_en   = 3'b111;
        fif.free_tag  = {6'd45, 6'd40, 6'd50};
        #1;
        chk("b_nobyp_rdy", 32'(fif.alloc_ready), 0);
        chk_grants("b_nobyp", 3'b000);
        tq.push_back(50);
        tq.push_back(40);
        tq.push_back(45);
        @(negedge clk);
        idle();
        #1;
        chk("b_fr_cnt", 32'(count), 3);
        @(negedge clk);
        fif.alloc_req = 3'b111;
        #1;
        chk_grants("b_wrap", 3'b111);
        @(negedge clk);
        idle();
        #1;
        chk("b_wrap_cnt", 32'(count), 0);
        chk("b_wrap_empty", 32'(empty), 1);
`ifdef FREE_LIST_STATS_EN
        chk("s_allocs", stat_allocs, 35);
        chk("s_frees", stat_frees, 3);
        chk("s_stalls", stat_stalls, 2);
        do_reset();
        #1;
        chk("s_rst_allocs", stat_allocs, 0);
`endif
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
        $finish;
    end

endmodule
